// File: rtl/memory_responder.sv
// ---------------------------------------------------------------------------
// memory_responder
//   Target side of the core's single-port memory bus. Backs the bus with a
//   word-organised on-chip RAM, applies byte-strobed writes and answers every
//   accepted request after a programmable number of cycles (LATENCY).
//
// Parameters
//   DEPTH      RAM size in 32-bit words (power of two, >= 2)
//   LATENCY    cycles from request acceptance to memory_ready (1..15)
//   BASE_ADDR  byte address of word 0 (aligned to 4*DEPTH)
//
// Ports
//   rst           in   async active-low reset
//   clk           in   clock, all state on rising edge
//   memory_valid  in   request present
//   memory_instr  in   instruction fetch (never writes)
//   memory_addr   in   byte address
//   memory_wdata  in   write data
//   memory_wstrb  in   byte write enables, 0 = read
//   memory_rdata  out  read data, 0 outside the ready cycle
//   memory_ready  out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module memory_responder #(
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        memory_valid,
    input  logic        memory_instr,
    input  logic [31:0] memory_addr,
    input  logic [31:0] memory_wdata,
    input  logic [3:0]  memory_wstrb,
    output logic [31:0] memory_rdata,
    output logic        memory_ready
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_ready;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [DEPTH];

    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [3:0]    w_wstrb;
    logic [31:0]   w_off;
    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic          w_fire;
    logic          w_wr;

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (memory_valid) w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
            // Counter holds the remaining wait cycles; the 1->0 step is the
            // edge that enters RESP.
            S_WAIT: if (r_cnt == 4'd1) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // With LATENCY=1 the RAM access happens on the acceptance edge itself,
    // so in IDLE the live bus is used; otherwise the captured copy.
    always_comb begin
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_wstrb = r_wstrb;
        if (r_state == S_IDLE) begin
            w_addr  = memory_addr;
            w_wdata = memory_wdata;
            w_wstrb = memory_instr ? 4'b0000 : memory_wstrb;
        end
    end

    // Unsigned offset: addresses below BASE_ADDR wrap to huge values and
    // fall out of range along with those above the top.
    assign w_off      = w_addr - BASE_ADDR;
    assign w_in_range = ((w_off >> (AW + 2)) == 32'd0);
    assign w_idx      = w_off[AW+1:2];
    assign w_fire     = (w_next == S_RESP);
    assign w_wr       = w_fire && w_in_range && (w_wstrb != 4'b0000);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wstrb <= 4'd0;
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && memory_valid) begin
                r_addr  <= memory_addr;
                r_wdata <= memory_wdata;
                r_wstrb <= memory_instr ? 4'b0000 : memory_wstrb;
                r_cnt   <= 4'(LATENCY - 1);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            r_ready <= w_fire;
            r_rdata <= (w_fire && w_in_range && (w_wstrb == 4'b0000)) ? r_mem[w_idx] : 32'd0;
        end
    end

    // RAM is not reset; writes are suppressed while reset is held so an
    // interrupted write can never land.
    always_ff @(posedge clk) begin
        if (rst && w_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wstrb[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    assign memory_ready = r_ready;
    assign memory_rdata = r_rdata;

endmodule

// File: tb/tb_memory_responder.sv
module tb_memory_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        v1, i1, r1;
    logic [31:0] a1, d1, q1;
    logic [3:0]  s1;
    logic        v4, i4, r4;
    logic [31:0] a4, d4, q4;
    logic [3:0]  s4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Single-cycle memory at 0x00..0x3F
    memory_responder #(.DEPTH(16), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) u_dut1 (
        .rst(rst), .clk(clk), .memory_valid(v1), .memory_instr(i1),
        .memory_addr(a1), .memory_wdata(d1), .memory_wstrb(s1),
        .memory_rdata(q1), .memory_ready(r1)
    );

    // Slow memory at 0x100..0x13F
    memory_responder #(.DEPTH(16), .LATENCY(4), .BASE_ADDR(32'h0000_0100)) u_dut4 (
        .rst(rst), .clk(clk), .memory_valid(v4), .memory_instr(i4),
        .memory_addr(a4), .memory_wdata(d4), .memory_wstrb(s4),
        .memory_rdata(q4), .memory_ready(r4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic instr,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        if (sel == 0) begin
            v1 = v; i1 = instr; a1 = addr; d1 = wdata; s1 = wstrb;
        end else begin
            v4 = v; i4 = instr; a4 = addr; d4 = wdata; s4 = wstrb;
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? r1 : r4;
    endfunction

    function automatic logic [31:0] rd(input int sel);
        return (sel == 0) ? q1 : q4;
    endfunction

    // Issue one request, hold it until ready, return data and latency
    // (cycles from the acceptance edge to the ready cycle).
    task automatic req(input int sel, input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       output logic [31:0] data, output int lat);
        @(negedge clk);
        drive(sel, 1'b1, instr, addr, wdata, wstrb);
        @(posedge clk); #1;
        lat = 1;
        while (!rdy(sel) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        data = rd(sel);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic quiet(input int sel, input string tag);
        @(posedge clk); #1;
        check({tag, "_ready"}, {31'd0, rdy(sel)}, 32'd0);
        check({tag, "_rdata"}, rd(sel), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int l;
        int n;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

        // Reset state
        #12;
        check("rst_ready1", {31'd0, r1}, 32'd0);
        check("rst_rdata1", q1, 32'd0);
        check("rst_ready4", {31'd0, r4}, 32'd0);
        check("rst_rdata4", q4, 32'd0);
        @(negedge clk); rst = 1'b1;

        // LATENCY=1 write then read
        req(0, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, d, l);
        check("l1_wr_lat", 32'(l), 32'd1);
        check("l1_wr_rdata", d, 32'd0);
        quiet(0, "l1_after_wr");
        req(0, 1'b0, 32'h10, 32'd0, 4'h0, d, l);
        check("l1_rd_lat", 32'(l), 32'd1);
        check("l1_rd_data", d, 32'hDEADBEEF);
        quiet(0, "l1_after_rd");

        // Byte strobes
        req(0, 1'b0, 32'h20, 32'h11223344, 4'hF, d, l);
        req(0, 1'b0, 32'h20, 32'hAABBCCDD, 4'b0101, d, l);
        req(0, 1'b0, 32'h20, 32'd0, 4'h0, d, l);
        check("strb_data", d, 32'h11BB33DD);

        // Fetch never writes
        req(0, 1'b1, 32'h20, 32'd0, 4'hF, d, l);
        check("fetch_data", d, 32'h11BB33DD);
        req(0, 1'b0, 32'h20, 32'd0, 4'h0, d, l);
        check("fetch_nowrite", d, 32'h11BB33DD);

        // Out of range just past the top (would alias word 0)
        req(0, 1'b0, 32'h0, 32'h0BADC0DE, 4'hF, d, l);
        req(0, 1'b0, 32'h40, 32'hCAFEF00D, 4'hF, d, l);
        check("oor1_wr_lat", 32'(l), 32'd1);
        check("oor1_wr_rdata", d, 32'd0);
        req(0, 1'b0, 32'h40, 32'd0, 4'h0, d, l);
        check("oor1_rd_data", d, 32'd0);
        req(0, 1'b0, 32'h0, 32'd0, 4'h0, d, l);
        check("oor1_word0", d, 32'h0BADC0DE);

        // LATENCY=4
        req(1, 1'b0, 32'h100, 32'h55AA55AA, 4'hF, d, l);
        check("l4_wr_lat", 32'(l), 32'd4);
        check("l4_wr_rdata", d, 32'd0);

        // Read held high across completion: pulse width and re-acceptance
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h100, 32'd0, 4'h0);
        @(posedge clk); #1;
        n = 1;
        while (!r4 && n < 40) begin @(posedge clk); #1; n++; end
        check("hold_lat", 32'(n), 32'd4);
        check("hold_data", q4, 32'h55AA55AA);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            if (n == 1) begin
                check("hold_pulse_ready", {31'd0, r4}, 32'd0);
                check("hold_pulse_rdata", q4, 32'd0);
            end
        end while (!r4 && n < 40);
        check("hold_gap", 32'(n), 32'd5);
        check("hold_data2", q4, 32'h55AA55AA);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

        // Out of range above and below the window
        req(1, 1'b0, 32'h140, 32'hFFFFFFFF, 4'hF, d, l);
        check("oor4_wr_lat", 32'(l), 32'd4);
        check("oor4_wr_rdata", d, 32'd0);
        req(1, 1'b0, 32'hFC, 32'd0, 4'h0, d, l);
        check("oor4_below_lat", 32'(l), 32'd4);
        check("oor4_below_rdata", d, 32'd0);
        req(1, 1'b0, 32'h100, 32'd0, 4'h0, d, l);
        check("oor4_word0", d, 32'h55AA55AA);

        // Reset during WAIT of a write
        req(1, 1'b0, 32'h104, 32'h12345678, 4'hF, d, l);
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h104, 32'hFFFFFFFF, 4'hF);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rstwait_ready", {31'd0, r4}, 32'd0);
        check("rstwait_rdata", q4, 32'd0);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk); rst = 1'b1;
        req(1, 1'b0, 32'h104, 32'd0, 4'h0, d, l);
        check("rstwait_lat", 32'(l), 32'd4);
        check("rstwait_word", d, 32'h12345678);

        // Reset during RESP drops outputs at once
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h100, 32'd0, 4'h0);
        @(posedge clk); #1;
        n = 1;
        while (!r4 && n < 40) begin @(posedge clk); #1; n++; end
        check("rstresp_pre_ready", {31'd0, r4}, 32'd1);
        #1 rst = 1'b0;
        #1;
        check("rstresp_ready", {31'd0, r4}, 32'd0);
        check("rstresp_rdata", q4, 32'd0);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk); rst = 1'b1;
        req(1, 1'b0, 32'h100, 32'd0, 4'h0, d, l);
        check("rstresp_lat", 32'(l), 32'd4);
        check("rstresp_word", d, 32'h55AA55AA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
